// File: rtl/program_loader.sv
// Boot-time program loader: pulls WORDS bytes from a byte source and writes them
// into CPU RAM through the shared bus (MAR address cycle, then RAM data cycle).
module program_loader #(
    parameter int WORDS   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic [7:0] bus_out,
    output logic       boot_write_to_bus,
    output logic       mar_read_from_bus,
    output logic       ram_read_from_bus,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LAST_ADDR = 4'(WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SET_ADDR  = 3'd2,
        WRITE_RAM = 3'd3,
        FINISH    = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    addr, addr_nxt;
    logic [7:0]    data_q, data_nxt;
    logic [TW-1:0] tmo, tmo_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= 4'd0;
            data_q <= 8'd0;
            tmo    <= '0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            data_q <= data_nxt;
            tmo    <= tmo_nxt;
        end
    end

    // Outputs depend only on registered state/addr/data, never directly on inputs.
    always_comb begin
        state_nxt         = state;
        addr_nxt          = addr;
        data_nxt          = data_q;
        tmo_nxt           = tmo;
        byte_ready        = 1'b0;
        bus_out           = 8'd0;
        boot_write_to_bus = 1'b0;
        mar_read_from_bus = 1'b0;
        ram_read_from_bus = 1'b0;
        cpu_hold          = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        error             = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = WAIT_BYTE;
                    addr_nxt  = 4'd0;
                    tmo_nxt   = '0;
                end
            end
            WAIT_BYTE: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
                if (abort) begin
                    state_nxt = FAIL;
                end else if (byte_valid) begin
                    data_nxt  = byte_data;
                    tmo_nxt   = '0;
                    state_nxt = SET_ADDR;
                end else if (tmo == TMO_LAST) begin
                    state_nxt = FAIL;
                end else begin
                    tmo_nxt = tmo + TW'(1);
                end
            end
            SET_ADDR: begin
                bus_out           = {4'h0, addr};
                boot_write_to_bus = 1'b1;
                mar_read_from_bus = 1'b1;
                cpu_hold          = 1'b1;
                busy              = 1'b1;
                state_nxt         = abort ? FAIL : WRITE_RAM;
            end
            WRITE_RAM: begin
                bus_out           = data_q;
                boot_write_to_bus = 1'b1;
                ram_read_from_bus = 1'b1;
                cpu_hold          = 1'b1;
                busy              = 1'b1;
                // The write on the bus this cycle still lands even if abort is seen now.
                if (abort) begin
                    state_nxt = FAIL;
                end else if (addr == LAST_ADDR) begin
                    state_nxt = FINISH;
                end else begin
                    addr_nxt  = addr + 4'd1;
                    state_nxt = WAIT_BYTE;
                end
            end
            FINISH: begin
                done      = 1'b1;
                cpu_hold  = 1'b1;
                state_nxt = IDLE;
            end
            FAIL: begin
                error     = 1'b1;
                cpu_hold  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: byte source model, bus/RAM scoreboard, scenario tasks.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;

    logic       byte_ready, boot_write_to_bus, mar_read_from_bus, ram_read_from_bus;
    logic       cpu_hold, busy, done, error;
    logic [7:0] bus_out;
    logic [2:0] state_dbg;

    logic       byte_ready_4, boot_4, mar_4, ram_4, cpu_hold_4, busy_4, done_4, error_4;
    logic [7:0] bus_out_4;
    logic [2:0] state_dbg_4;

    program_loader #(.WORDS(16), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .bus_out(bus_out), .boot_write_to_bus(boot_write_to_bus),
        .mar_read_from_bus(mar_read_from_bus), .ram_read_from_bus(ram_read_from_bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    program_loader #(.WORDS(4), .TIMEOUT(20)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_4),
        .bus_out(bus_out_4), .boot_write_to_bus(boot_4),
        .mar_read_from_bus(mar_4), .ram_read_from_bus(ram_4),
        .cpu_hold(cpu_hold_4), .busy(busy_4), .done(done_4), .error(error_4),
        .state_dbg(state_dbg_4)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- byte source ----------------
    // Valid/ready: a byte transfers on a rising edge where byte_valid and byte_ready are
    // both high; the source then advances to the next byte. Valid pulses once every
    // (src_gap+1) cycles and is withdrawn if not taken.
    logic       src_on = 1'b0;
    logic       src_sel4 = 1'b0;
    logic [7:0] src_base = 8'd0;
    int         src_count = 0;
    int         src_gap = 0;
    int         src_idx = 0;
    int         src_phase = 0;
    logic       take = 1'b0;

    always begin
        @(negedge clk);
        take = byte_valid && (src_sel4 ? byte_ready_4 : byte_ready);
        @(posedge clk);
        #1;
        if (!src_on) begin
            src_idx    = 0;
            src_phase  = 0;
            byte_valid = 1'b0;
            byte_data  = 8'd0;
        end else begin
            if (take) src_idx++;
            byte_valid = (src_idx < src_count) && ((src_phase % (src_gap + 1)) == 0);
            byte_data  = src_base + 8'(src_idx);
            src_phase++;
        end
    end

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [11:0] exp4_q[$];
    logic        mon16 = 1'b0;
    logic        mon4 = 1'b0;
    logic [3:0]  mar_q = 4'd0;
    logic [3:0]  mar4_q = 4'd0;
    int total = 0;
    int bad = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int wr4_cnt = 0, done4_cnt = 0, err4_cnt = 0;

    // Advance one cycle; sample at the falling edge and check the RAM write stream.
    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        total++;
        if ((mar_read_from_bus && ram_read_from_bus) ||
            (boot_write_to_bus != (mar_read_from_bus || ram_read_from_bus))) begin
            bad++;
            $display("FAIL lane_select: mar=%b ram=%b boot=%b required exclusive, boot=mar|ram",
                     mar_read_from_bus, ram_read_from_bus, boot_write_to_bus);
        end
        total++;
        if ((mar_4 && ram_4) || (boot_4 != (mar_4 || ram_4))) begin
            bad++;
            $display("FAIL lane_select_4: mar=%b ram=%b boot=%b required exclusive, boot=mar|ram",
                     mar_4, ram_4, boot_4);
        end
        if (mon16) begin
            if (ram_read_from_bus) begin
                total++;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL ram_write: got addr=%0d data=%h, required no write",
                             mar_q, bus_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({mar_q, bus_out} !== e) begin
                        bad++;
                        $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 mar_q, bus_out, e[11:8], e[7:0]);
                    end
                end
            end
            if (mar_read_from_bus) mar_q = bus_out[3:0];
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (byte_ready) begin
                total++;
                if (mar_read_from_bus || ram_read_from_bus || done || error || !cpu_hold) begin
                    bad++;
                    $display("FAIL ready_state: byte_ready with mar=%b ram=%b done=%b err=%b hold=%b",
                             mar_read_from_bus, ram_read_from_bus, done, error, cpu_hold);
                end
            end
        end
        if (mon4) begin
            if (ram_4) begin
                total++;
                wr4_cnt++;
                if (exp4_q.size() == 0) begin
                    bad++;
                    $display("FAIL ram_write_4: got addr=%0d data=%h, required no write",
                             mar4_q, bus_out_4);
                end else begin
                    e = exp4_q.pop_front();
                    if ({mar4_q, bus_out_4} !== e) begin
                        bad++;
                        $display("FAIL ram_write_4: got addr=%0d data=%h, required addr=%0d data=%h",
                                 mar4_q, bus_out_4, e[11:8], e[7:0]);
                    end
                end
            end
            if (mar_4) mar4_q = bus_out_4[3:0];
            if (done_4) done4_cnt++;
            if (error_4) err4_cnt++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_on   = 1'b0;
        src_sel4 = 1'b0;
        mon16    = 1'b0;
        mon4     = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        exp4_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic begin_session(input logic [7:0] base, input int count, input int gap,
                                 input logic sel4);
        src_base  = base;
        src_count = count;
        src_gap   = gap;
        src_sel4  = sel4;
        src_on    = 1'b1;
        abort     = 1'b0;
        start     = 1'b1;
    endtask

    function automatic logic [15:0] outs16();
        return {byte_ready, bus_out, boot_write_to_bus, mar_read_from_bus,
                ram_read_from_bus, cpu_hold, busy, done, error};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs16() !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0000", outs16());
        end
        repeat (2) tick();
        rst_n = 1'b1;
        // A byte offered while idle must not be taken.
        src_base = 8'h3C; src_count = 1; src_gap = 0; src_sel4 = 1'b0; src_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (outs16() !== 16'h0 || state_dbg !== 3'd0) begin
                bad++;
                $display("FAIL idle_outputs: got outs=%h state=%0d required 0000/0",
                         outs16(), state_dbg);
            end
        end
        src_on = 1'b0;
    endtask

    task automatic test_full_load();
        int d0, e0, w0, done_at;
        logic hold49, hold50;
        do_reset();
        mon16 = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(i)});
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; done_at = -1;
        hold49 = 1'b0; hold50 = 1'b1;
        begin_session(8'h00, 16, 0, 1'b0);
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (done && done_at < 0) done_at = k;
            if (k == 49) hold49 = cpu_hold;
            if (k == 50) hold50 = cpu_hold;
        end
        total++;
        if (done_at !== 49) begin bad++; $display("FAIL full_done_cycle: got %0d required 49", done_at); end
        total++;
        if (hold49 !== 1'b1 || hold50 !== 1'b0) begin
            bad++;
            $display("FAIL full_cpu_hold: got c49=%b c50=%b required 1/0", hold49, hold50);
        end
        total++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++;
            $display("FAIL full_pulses: got done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
        end
        total++;
        if (wr_cnt - w0 != 16 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_writes: got %0d left=%0d required 16/0", wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_gapped();
        int d0, e0, w0;
        logic seen;
        do_reset();
        mon16 = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(i)});
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; seen = 1'b0;
        begin_session(8'h00, 16, 3, 1'b0);
        for (int k = 1; k <= 200 && !seen; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            seen = done;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL gapped_timeout: got no done in 200 cycles required done"); end
        total++;
        if (wr_cnt - w0 != 16 || exp_q.size() != 0 || err_cnt != e0 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL gapped_result: got writes=%0d left=%0d err=%0d done=%0d required 16/0/0/1",
                     wr_cnt - w0, exp_q.size(), err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int d0, e0, w0;
        do_reset();
        mon16 = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back({4'(i), 8'(8'h50 + i)});
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        begin_session(8'h50, 16, 0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (ram_read_from_bus && wr_cnt - w0 == 5) abort = 1'b1;
        end
        abort = 1'b0;
        total++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            bad++;
            $display("FAIL abort_pulses: got err=%0d done=%0d required 1/0", err_cnt - e0, done_cnt - d0);
        end
        total++;
        if (wr_cnt - w0 != 5 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL abort_writes: got %0d left=%0d required 5/0", wr_cnt - w0, exp_q.size());
        end
        total++;
        if (outs16() !== 16'h0) begin bad++; $display("FAIL abort_idle: got %h required 0000", outs16()); end
    endtask

    task automatic test_timeout();
        int d0, w0, err_at;
        do_reset();
        mon16 = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), 8'(8'h40 + i)});
        d0 = done_cnt; w0 = wr_cnt; err_at = -1;
        begin_session(8'h40, 3, 0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (error && err_at < 0) err_at = k;
        end
        total++;
        if (err_at !== 20) begin bad++; $display("FAIL timeout_cycle: got %0d required 20", err_at); end
        total++;
        if (wr_cnt - w0 != 3 || exp_q.size() != 0 || done_cnt != d0) begin
            bad++;
            $display("FAIL timeout_writes: got writes=%0d left=%0d done=%0d required 3/0/0",
                     wr_cnt - w0, exp_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, e0, w0;
        logic hit;
        do_reset();
        mon16 = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back({4'(i), 8'(8'h10 + i)});
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; hit = 1'b0;
        begin_session(8'h10, 16, 0, 1'b0);
        for (int k = 1; k <= 40 && !hit; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            hit = ram_read_from_bus && (wr_cnt - w0 == 8);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL resetmid_reach: got no write of addr 7 required one"); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs16() !== 16'h0) begin bad++; $display("FAIL resetmid_outputs: got %h required 0000", outs16()); end
        src_on = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        total++;
        if (done_cnt != d0 || err_cnt != e0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL resetmid_pulses: got done=%0d err=%0d left=%0d required 0/0/0",
                     done_cnt - d0, err_cnt - e0, exp_q.size());
        end
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(8'h80 + i)});
        d0 = done_cnt;
        begin_session(8'h80, 16, 0, 1'b0);
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        total++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || err_cnt != e0) begin
            bad++;
            $display("FAIL resetmid_reload: got done=%0d left=%0d err=%0d required 1/0/0",
                     done_cnt - d0, exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        do_reset();
        mon4 = 1'b1;
        for (int i = 0; i < 8; i++) exp4_q.push_back({4'(i % 4), 8'(8'h20 + i)});
        d1 = -1; d2 = -1;
        begin_session(8'h20, 8, 0, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_4) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) begin d2 = k; start = 1'b0; end
            end
        end
        total++;
        if (d1 !== 13 || d2 !== 27) begin
            bad++;
            $display("FAIL b2b_done_cycles: got %0d/%0d required 13/27", d1, d2);
        end
        total++;
        if (wr4_cnt != 8 || exp4_q.size() != 0 || err4_cnt != 0 || done4_cnt != 2) begin
            bad++;
            $display("FAIL b2b_writes: got writes=%0d left=%0d err=%0d done=%0d required 8/0/0/2",
                     wr4_cnt, exp4_q.size(), err4_cnt, done4_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_load();
        test_gapped();
        test_abort();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL provide parameter WORDS, default 16, number of RAM bytes loaded per session (1..16).
REQ-002 SHALL provide parameter TIMEOUT, default 1000, maximum cycles waiting for a byte before error (>=2).
REQ-003 SHALL provide port clk  input  1  single clock, all state on rising edge; same clock as the CPU datapath.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  level; begins a session when sampled high in IDLE.
REQ-006 SHALL provide port abort  input  1  level; cancels an active session.
REQ-007 SHALL provide port byte_valid  input  1  source has a byte on byte_data.
REQ-008 SHALL provide port byte_data  input  8  program byte.
REQ-009 SHALL provide port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL provide port bus_out  output  8  lane data for the shared CPU bus.
REQ-011 SHALL provide port boot_write_to_bus  output  1  bus lane select for bus_out.
REQ-012 SHALL provide port mar_read_from_bus  output  1  MAR latches bus[3:0].
REQ-013 SHALL provide port ram_read_from_bus  output  1  RAM writes bus at MAR address.
REQ-014 SHALL provide port cpu_hold  output  1  holds CPU control/PC inactive while loading.
REQ-015 SHALL provide port busy, done, error  output  1 each  status; done and error are single-cycle pulses.

Function
REQ-016 SHALL implement states IDLE, WAIT_BYTE, SET_ADDR, WRITE_RAM, FINISH, FAIL; all outputs decoded from registered state/data only (no input-to-output combinational path).
REQ-017 SHALL in IDLE: all outputs 0, bus_out 0; start=1 and abort=0 -> WAIT_BYTE, addr counter cleared to 0.
REQ-018 SHALL in WAIT_BYTE: byte_ready=1, cpu_hold=1, busy=1; on byte_valid&byte_ready capture byte_data, clear timeout counter -> SET_ADDR.
REQ-019 SHALL in SET_ADDR (exactly 1 cycle): bus_out={4'h0,addr}, boot_write_to_bus=1, mar_read_from_bus=1 -> WRITE_RAM.
REQ-020 SHALL in WRITE_RAM (exactly 1 cycle): bus_out=captured byte, boot_write_to_bus=1, ram_read_from_bus=1; if addr==WORDS-1 -> FINISH, else addr+1 -> WAIT_BYTE.
REQ-021 SHALL never assert mar_read_from_bus and ram_read_from_bus in the same cycle; boot_write_to_bus=1 iff one of them is 1.
REQ-022 SHALL produce minimum 3 cycles per byte (accept, SET_ADDR, WRITE_RAM); full WORDS=16 load with byte_valid held high completes FINISH at cycle 49 after start sampled.
REQ-023 SHALL in FINISH (1 cycle): done=1, cpu_hold=1 -> IDLE; cpu_hold drops the cycle after FINISH.
REQ-024 SHALL count cycles spent in WAIT_BYTE with byte_valid=0; reaching TIMEOUT -> FAIL.
REQ-025 SHALL in FAIL (1 cycle): error=1, cpu_hold=1 -> IDLE; no further RAM writes.
REQ-026 SHALL treat abort=1 in WAIT_BYTE, SET_ADDR or WRITE_RAM as highest priority: next state FAIL, current RAM write cycle not started if not already in WRITE_RAM.
REQ-027 SHALL ignore start outside IDLE; start held high after FINISH/FAIL begins a new session on the following IDLE cycle.
REQ-028 SHALL hold addr within 0..WORDS-1; never wrap to 0 mid-session.
REQ-029 SHALL keep byte_ready=0 in all states except WAIT_BYTE; a byte_valid outside WAIT_BYTE is not consumed.

Reset
REQ-030 SHALL on rst_n=0, asynchronously: state IDLE, addr 0, timeout counter 0, captured byte 0, all outputs 0.
REQ-031 SHALL on reset mid-session abandon the session without a done or error pulse; RAM contents already written are not restored.
REQ-032 SHALL leave reset synchronously on the first rising clk after rst_n deasserts, in IDLE.

Verification
REQ-033 SHALL cover: start, 16 bytes 0x00..0x0F with byte_valid always high -> 16 MAR writes addr 0..15, RAM data matches, done pulse at cycle 49, cpu_hold low cycle 50.
REQ-034 SHALL cover: byte_valid toggling 1 cycle on/3 off -> same RAM image, no dropped/duplicated byte, byte_ready only in WAIT_BYTE.
REQ-035 SHALL cover: abort asserted after 5th byte accepted -> exactly 5 writes (addr 0..4), error pulse, no done, return to IDLE.
REQ-036 SHALL cover: TIMEOUT=10, no byte after 3rd -> error pulse 10 cycles into WAIT_BYTE, 3 writes total.
REQ-037 SHALL cover: rst_n low during WRITE_RAM of addr 7 -> all outputs 0 immediately, no done/error, next start reloads from addr 0.
REQ-038 SHALL cover: WORDS=4 with start held high -> done after 4 writes, second session begins automatically, assertion of REQ-021 never violated.
